// File: rtl/ecc_alu_sched.sv
// rtl/ecc_alu_sched.sv - instruction sequencer and register file in front of the modular ALU wrapper
//
// Buffers instruction words in a small FIFO, holds operands in a local register
// file, issues one ALU operation at a time and writes r/rswap back on alu_vld.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready/in_instr
//                   instruction stream {opcode[3:0],swapop,swapvl,cin,srca,srcb,dsta,dstb}
//   hwr_en/hwr_addr/hwr_data
//                   host register write port
//   hrd_addr/hrd_data
//                   host register read port, registered, read-before-write
//   alu_en          one-cycle start pulse to the ALU
//   alu_a/alu_b/alu_opcode/alu_swapop/alu_swapvl/alu_cin
//                   operands and controls, held from ISSUE through WAIT
//   alu_status/alu_vld/alu_r/alu_rswap
//                   ALU status and results
//   busy            FIFO non-empty or an instruction in flight
//   done            one-cycle pulse per completed instruction
//   err_illegal     one-cycle pulse when an instruction is dropped as illegal
//   err_tmo         sticky timeout flag, cleared only by rst
module ecc_alu_sched #(
  parameter int WID  = 256,
  parameter int NREG = 16,
  parameter int FDEP = 4,
  parameter int TMO  = 4096,
  localparam int AW  = $clog2(NREG),
  localparam int IW  = 7 + 4 * AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_instr,
  input  logic           hwr_en,
  input  logic [AW-1:0]  hwr_addr,
  input  logic [WID-1:0] hwr_data,
  input  logic [AW-1:0]  hrd_addr,
  output logic [WID-1:0] hrd_data,
  output logic           alu_en,
  output logic [WID-1:0] alu_a,
  output logic [WID-1:0] alu_b,
  output logic [3:0]     alu_opcode,
  output logic           alu_swapop,
  output logic           alu_swapvl,
  output logic           alu_cin,
  input  logic [1:0]     alu_status,
  input  logic           alu_vld,
  input  logic [WID-1:0] alu_r,
  input  logic [WID-1:0] alu_rswap,
  output logic           busy,
  output logic           done,
  output logic           err_illegal,
  output logic           err_tmo
);

  localparam int FAW = $clog2(FDEP);
  localparam int CW  = $clog2(TMO);
  localparam logic [FAW-1:0] PTR_ONE  = FAW'(1);
  localparam logic [FAW:0]   CNT_ONE  = (FAW + 1)'(1);
  localparam logic [FAW:0]   CNT_FULL = (FAW + 1)'(FDEP);
  localparam logic [CW-1:0]  TMO_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0]  TMO_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;

  // Instruction FIFO
  logic [IW-1:0]  fifo_mem [FDEP];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FAW:0]   fifo_cnt;
  logic           push;
  logic           pop;
  logic [IW-1:0]  head;

  // Register file (not reset)
  logic [WID-1:0] rf [NREG];

  // Destinations of the instruction in flight
  logic [AW-1:0]  dsta_r;
  logic [AW-1:0]  dstb_r;
  logic [CW-1:0]  tmo_cnt;
  logic           wb;

  // Head-of-FIFO fields
  logic [3:0]     h_opcode;
  logic           h_swapop;
  logic           h_swapvl;
  logic           h_cin;
  logic [AW-1:0]  h_srca;
  logic [AW-1:0]  h_srcb;
  logic [AW-1:0]  h_dsta;
  logic [AW-1:0]  h_dstb;
  logic           h_illegal;

  assign head      = fifo_mem[rd_ptr];
  assign h_dstb    = head[AW-1:0];
  assign h_dsta    = head[2*AW-1:AW];
  assign h_srcb    = head[3*AW-1:2*AW];
  assign h_srca    = head[4*AW-1:3*AW];
  assign h_cin     = head[4*AW];
  assign h_swapvl  = head[4*AW+1];
  assign h_swapop  = head[4*AW+2];
  assign h_opcode  = head[4*AW+6:4*AW+3];
  // INV-class opcode without the swap qualifier never raises vld in the ALU.
  assign h_illegal = (h_opcode[1:0] == 2'b11) && !h_swapop;

  assign in_ready = (fifo_cnt != CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fifo_cnt != '0) && (alu_status == 2'b00);
  assign busy     = (fifo_cnt != '0) || (state != IDLE);
  assign wb       = (state == WAIT) && alu_vld;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Later assignments win: writeback beats a same-index host write, and
  // rswap beats r when dsta==dstb.
  always_ff @(posedge clk) begin
    if (hwr_en) begin
      rf[hwr_addr] <= hwr_data;
    end
    if (wb) begin
      rf[dsta_r] <= alu_r;
      if (alu_swapop) begin
        rf[dstb_r] <= alu_rswap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hrd_data <= '0;
    end else begin
      hrd_data <= rf[hrd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_en      <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      alu_swapop  <= 1'b0;
      alu_swapvl  <= 1'b0;
      alu_cin     <= 1'b0;
      dsta_r      <= '0;
      dstb_r      <= '0;
      tmo_cnt     <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_tmo     <= 1'b0;
    end else begin
      alu_en      <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a       <= rf[h_srca];
            alu_b       <= rf[h_srcb];
            alu_opcode  <= h_opcode;
            alu_swapop  <= h_swapop;
            alu_swapvl  <= h_swapvl;
            alu_cin     <= h_cin;
            dsta_r      <= h_dsta;
            dstb_r      <= h_dstb;
            // Outputs are registered, so the ISSUE-cycle pulses are set here.
            err_illegal <= h_illegal;
            alu_en      <= !h_illegal;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          if ((alu_opcode[1:0] == 2'b11) && !alu_swapop) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (alu_vld) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            // The hung ALU keeps status busy, which blocks any further issue.
            err_tmo <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_alu_sched.sv
// tb/tb_ecc_alu_sched.sv - randomized self-checking bench for ecc_alu_sched
module tb_ecc_alu_sched;

  localparam int WID  = 64;
  localparam int NREG = 16;
  localparam int FDEP = 4;
  localparam int TMO  = 16;
  localparam int AW   = 4;
  localparam int IW   = 7 + 4 * AW;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_instr;
  logic           hwr_en;
  logic [AW-1:0]  hwr_addr;
  logic [WID-1:0] hwr_data;
  logic [AW-1:0]  hrd_addr;
  logic [WID-1:0] hrd_data;
  logic           alu_en;
  logic [WID-1:0] alu_a;
  logic [WID-1:0] alu_b;
  logic [3:0]     alu_opcode;
  logic           alu_swapop;
  logic           alu_swapvl;
  logic           alu_cin;
  logic [1:0]     alu_status;
  logic           alu_vld;
  logic [WID-1:0] alu_r;
  logic [WID-1:0] alu_rswap;
  logic           busy;
  logic           done;
  logic           err_illegal;
  logic           err_tmo;

  ecc_alu_sched #(.WID(WID), .NREG(NREG), .FDEP(FDEP), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .hwr_en(hwr_en), .hwr_addr(hwr_addr), .hwr_data(hwr_data),
    .hrd_addr(hrd_addr), .hrd_data(hrd_data),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_swapop(alu_swapop), .alu_swapvl(alu_swapvl), .alu_cin(alu_cin),
    .alu_status(alu_status), .alu_vld(alu_vld), .alu_r(alu_r), .alu_rswap(alu_rswap),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic          swop;
    logic          swvl;
    logic          cin;
    logic [AW-1:0] sa;
    logic [AW-1:0] sb;
    logic [AW-1:0] da;
    logic [AW-1:0] db;
  } ins_t;

  int n_vec = 0;
  int n_bad = 0;

  logic [WID-1:0] mrf [NREG];
  ins_t exp_q[$];

  logic stall = 1'b0;
  logic hang = 1'b0;
  logic hung = 1'b0;
  logic pending = 1'b0;
  int   fixed_lat = -1;

  int done_cnt = 0;
  int ill_cnt = 0;
  int en_cnt = 0;

  assign alu_status = (stall || pending || hung) ? 2'b01 : 2'b00;

  task automatic check(input string tag, input logic [WID-1:0] got, input logic [WID-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input ins_t e);
    return !((e.op[1:0] == 2'b11) && !e.swop);
  endfunction

  // Pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      if (done)        done_cnt++;
      if (err_illegal) ill_cnt++;
      if (alu_en)      en_cnt++;
    end
  end

  // Behavioural ALU: checks operands against the model register file at issue,
  // answers after a random latency, then retires the instruction in the model.
  initial begin
    ins_t e;
    logic [WID-1:0] a, b, r, rs;
    int lat;
    alu_vld = 1'b0;
    alu_r = '0;
    alu_rswap = '0;
    forever begin
      @(negedge clk);
      if (!rst && alu_en) begin
        if (hang) begin
          hung = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          check("issue_without_pending_instr", WID'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          pending = 1'b1;
          a = mrf[e.sa];
          b = mrf[e.sb];
          check("alu_a", alu_a, a);
          check("alu_b", alu_b, b);
          check("alu_opcode", WID'(alu_opcode), WID'(e.op));
          check("alu_ctl", WID'({alu_swapop, alu_swapvl, alu_cin}), WID'({e.swop, e.swvl, e.cin}));
          if (e.swop) begin
            r  = e.swvl ? b : a;
            rs = e.swvl ? a : b;
          end else begin
            r  = a + b + WID'(e.cin);
            rs = '0;
          end
          lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
          repeat (lat + 1) @(negedge clk);
          check("alu_a_held", alu_a, a);
          check("alu_en_pulse", WID'(alu_en), 0);
          alu_vld = 1'b1;
          alu_r = r;
          alu_rswap = rs;
          @(negedge clk);
          alu_vld = 1'b0;
          pending = 1'b0;
          mrf[e.da] = r;
          if (e.swop) mrf[e.db] = rs;
        end
      end
    end
  end

  task automatic host_wr(input logic [AW-1:0] a, input logic [WID-1:0] d);
    hwr_en = 1'b1;
    hwr_addr = a;
    hwr_data = d;
    @(negedge clk);
    hwr_en = 1'b0;
    mrf[a] = d;
  endtask

  task automatic host_rd(input logic [AW-1:0] a, output logic [WID-1:0] d);
    hrd_addr = a;
    @(negedge clk);
    d = hrd_data;
  endtask

  task automatic push(input ins_t e);
    int t;
    t = 0;
    in_instr = {e.op, e.swop, e.swvl, e.cin, e.sa, e.sb, e.da, e.db};
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_wait", WID'(in_ready), 1);
    end else if (is_legal(e)) begin
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || pending) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", WID'(busy || pending), 0);
    @(negedge clk);
  endtask

  function automatic ins_t mk(input logic [3:0] op, input logic swop, input logic swvl,
                              input logic cin, input int sa, input int sb, input int da,
                              input int db);
    ins_t e;
    e.op = op; e.swop = swop; e.swvl = swvl; e.cin = cin;
    e.sa = AW'(sa); e.sb = AW'(sb); e.da = AW'(da); e.db = AW'(db);
    return e;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WID-1:0] d, va, vb;
    int d0, i0, e0, t, exp_done, exp_ill;
    ins_t e;

    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    hwr_en = 1'b0;
    hwr_addr = '0;
    hwr_data = '0;
    hrd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", WID'(in_ready), 1);
    check("rst_busy", WID'(busy), 0);
    check("rst_alu_en", WID'(alu_en), 0);
    check("rst_done", WID'(done), 0);
    check("rst_err", WID'({err_illegal, err_tmo}), 0);
    check("rst_hrd_data", hrd_data, 0);
    check("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NREG; i++) host_wr(AW'(i), {$urandom, $urandom});

    // FA directed
    host_wr(0, 5);
    host_wr(1, 7);
    d0 = done_cnt; e0 = en_cnt;
    fixed_lat = 2;
    push(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0));
    wait_idle();
    host_rd(2, d);
    check("fa_rf2", d, 12);
    check("fa_en_count", WID'(en_cnt - e0), 1);
    check("fa_done_count", WID'(done_cnt - d0), 1);

    // SWAP directed
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
    host_wr(3, va);
    host_wr(4, vb);
    d0 = done_cnt;
    push(mk(4'b0011, 1, 1, 0, 3, 4, 3, 4));
    wait_idle();
    host_rd(3, d);
    check("swap_rf3", d, vb);
    host_rd(4, d);
    check("swap_rf4", d, va);
    check("swap_done_count", WID'(done_cnt - d0), 1);

    // Illegal then legal
    d0 = done_cnt; i0 = ill_cnt; e0 = en_cnt;
    fixed_lat = -1;
    push(mk(4'b0011, 0, 0, 0, 5, 6, 7, 8));
    push(mk(4'b0000, 0, 0, 1, 5, 6, 9, 0));
    wait_idle();
    check("illegal_pulses", WID'(ill_cnt - i0), 1);
    check("illegal_en_count", WID'(en_cnt - e0), 1);
    check("illegal_done_count", WID'(done_cnt - d0), 1);

    // Backpressure: RAW chain through dst 8..12
    d0 = done_cnt; e0 = en_cnt;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push(mk(4'b0000, 0, 0, 0, (i == 0) ? 0 : 8 + i - 1, 1, 8 + i, 0));
    check("bp_in_ready_full", WID'(in_ready), 0);
    check("bp_no_issue", WID'(en_cnt - e0), 0);
    stall = 1'b0;
    push(mk(4'b0000, 0, 0, 0, 11, 1, 12, 0));
    wait_idle();
    check("bp_done_count", WID'(done_cnt - d0), 5);
    for (int i = 8; i < 13; i++) begin
      host_rd(AW'(i), d);
      check("bp_dst", d, mrf[i]);
    end

    // Random stream
    d0 = done_cnt; i0 = ill_cnt;
    exp_done = 0; exp_ill = 0;
    for (int n = 0; n < 40; n++) begin
      e = mk(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15));
      if (is_legal(e)) exp_done++;
      else exp_ill++;
      push(e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    check("rand_done_count", WID'(done_cnt - d0), WID'(exp_done));
    check("rand_illegal_count", WID'(ill_cnt - i0), WID'(exp_ill));

    // Collisions: same index (writeback wins), different index (both land)
    host_wr(0, 5);
    host_wr(1, 7);
    fixed_lat = 0;
    for (int k = 0; k < 2; k++) begin
      push(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0));
      t = 0;
      while (!alu_en && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("col_issue", WID'(alu_en), 1);
      @(negedge clk);
      hwr_en = 1'b1;
      hwr_addr = (k == 0) ? AW'(2) : AW'(5);
      hwr_data = (k == 0) ? WID'(9) : WID'(85);
      mrf[hwr_addr] = hwr_data;
      @(negedge clk);
      hwr_en = 1'b0;
      wait_idle();
    end
    fixed_lat = -1;
    host_rd(2, d);
    check("col_rf2_writeback_wins", d, 12);
    host_rd(5, d);
    check("col_rf5_host_lands", d, 85);

    for (int i = 0; i < NREG; i++) begin
      host_rd(AW'(i), d);
      check("rf_final", d, mrf[i]);
    end

    // Timeout
    hang = 1'b1;
    push(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0));
    t = 0;
    while (!alu_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("tmo_issue", WID'(alu_en), 1);
    repeat (TMO) @(negedge clk);
    check("tmo_not_yet", WID'(err_tmo), 0);
    @(negedge clk);
    check("tmo_flag", WID'(err_tmo), 1);
    check("tmo_busy_idle", WID'(busy), 0);
    e0 = en_cnt;
    push(mk(4'b0000, 0, 0, 0, 0, 1, 3, 0));
    check("tmo_busy_fifo", WID'(busy), 1);
    repeat (20) @(negedge clk);
    check("tmo_no_issue", WID'(en_cnt - e0), 0);
    check("tmo_sticky", WID'(err_tmo), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    hung = 1'b0;
    hang = 1'b0;
    exp_q.delete();
    check("rst2_err_tmo", WID'(err_tmo), 0);
    check("rst2_in_ready", WID'(in_ready), 1);
    check("rst2_busy", WID'(busy), 0);
    check("rst2_alu_en", WID'(alu_en), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle", WID'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
